// File: rtl/detector_pkg.sv
// detector_pkg: shared constants and arbiter state encoding for the
// symbol-pattern detector slice.
package detector_pkg;

  localparam int unsigned SYM_W_DEFAULT = 5;

  // Symbols the detector matches on
  localparam logic [SYM_W_DEFAULT-1:0] SYM_A = 5'd1;
  localparam logic [SYM_W_DEFAULT-1:0] SYM_C = 5'd3;
  localparam logic [SYM_W_DEFAULT-1:0] SYM_S = 5'd20;

  // Arbiter state encoding, kept numerically identical to the legacy values
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_CLEAR  = 2'd1;
  localparam arb_state_t ST_STREAM = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker. Searches upward from last+1,
// wrapping back to 0, and reports the first requester found.
module rr_pick
  import detector_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic [IDW-1:0]   gnt_id,
  output logic             any
);

  logic           w_hi_found;
  logic           w_lo_found;
  logic [IDW-1:0] w_hi_id;
  logic [IDW-1:0] w_lo_id;

  // Descending scan: lowest requester above `last` wins, else lowest at/below
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_id    = '0;
    w_lo_id    = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (req[IDW'(i - 32'd1)]) begin
        if (IDW'(i - 32'd1) > last) begin
          w_hi_found = 1'b1;
          w_hi_id    = IDW'(i - 32'd1);
        end else begin
          w_lo_found = 1'b1;
          w_lo_id    = IDW'(i - 32'd1);
        end
      end
    end
    gnt_id = w_hi_found ? w_hi_id : w_lo_id;
    any    = w_hi_found | w_lo_found;
  end

endmodule

// File: rtl/detector_stream_arbiter.sv
// detector_stream_arbiter: word-level round-robin arbiter sharing one
// symbol-pattern detector among N_REQ valid/ready symbol sources. The grant
// is held for a whole word and the detector is cleared before each word.
// Optional stall timeout enabled with `define ARB_TIMEOUT_EN.
module detector_stream_arbiter
  import detector_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned SYM_W   = SYM_W_DEFAULT,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*SYM_W-1:0]    req_sym,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [SYM_W-1:0]          det_sym,
  output logic                      det_valid,
  input  logic                      det_ready,
  output logic                      det_clear,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic [15:0]               pkt_count
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                      timeout_flag
`endif
);

  localparam int unsigned IDW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || SYM_W < 1 || TIMEOUT < 1) begin : g_cfg_check
    $error("detector_stream_arbiter: unsupported parameter set");
  end

  arb_state_t     r_state;
  logic [IDW-1:0] r_grant;
  logic [IDW-1:0] r_last;
  logic [15:0]    r_pkt;

  logic [IDW-1:0] w_pick;
  logic           w_any;
  logic           w_in_stream;
  logic           w_own_valid;
  logic           w_xfer;
  logic           w_done;
  logic           w_abort_clear;
  logic [SYM_W-1:0] w_syms [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_syms[gi] = req_sym[gi*SYM_W +: SYM_W];
  end

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req    (req_valid),
    .last   (r_last),
    .gnt_id (w_pick),
    .any    (w_any)
  );

  assign w_in_stream = (r_state == ST_STREAM);
  assign w_own_valid = req_valid[r_grant];
  assign w_xfer      = w_in_stream & w_own_valid & det_ready;
  assign w_done      = w_xfer & req_last[r_grant];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_stall;
  logic             r_abort;
  logic             r_to_flag;
  logic             w_timeout;

  // Only owner-idle cycles with the detector ready count toward the limit
  assign w_timeout = w_in_stream & ~w_own_valid & det_ready &
                     (r_stall == CNT_W'(TIMEOUT - 1));

  // Stall counter, one-cycle abort clear pulse and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall   <= '0;
      r_abort   <= 1'b0;
      r_to_flag <= 1'b0;
    end else begin
      r_abort <= w_timeout;
      if (w_timeout) begin
        r_to_flag <= 1'b1;
      end
      if (!w_in_stream || w_xfer || w_timeout) begin
        r_stall <= '0;
      end else if (!w_own_valid && det_ready) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  assign w_abort_clear = r_abort;
  assign timeout_flag  = r_to_flag;
`else
  assign w_abort_clear = 1'b0;
`endif

  // Arbitration FSM: grant in IDLE, clear detector, stream until last
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= IDW'(N_REQ - 1);
      r_pkt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: r_state <= ST_STREAM;
        ST_STREAM: begin
          if (w_done) begin
            r_last  <= r_grant;
            r_pkt   <= r_pkt + 16'd1;
            r_state <= ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (w_timeout) begin
            r_last  <= r_grant;
            r_state <= ST_IDLE;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pass the owner's stream through to the detector while streaming
  always_comb begin
    req_ready = '0;
    det_valid = 1'b0;
    det_sym   = '0;
    if (w_in_stream) begin
      det_valid          = w_own_valid;
      det_sym            = w_syms[r_grant];
      req_ready[r_grant] = det_ready;
    end
  end

  assign det_clear = (r_state == ST_CLEAR) | w_abort_clear;
  assign busy      = (r_state != ST_IDLE);
  assign grant_id  = r_grant;
  assign pkt_count = r_pkt;

endmodule

// File: tb/tb_detector_stream_arbiter.sv
// tb_detector_stream_arbiter: directed stimulus against a cycle-level
// behavioural model, plus literal checks of symbol order, grant order and
// timing. Timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_detector_stream_arbiter;
  import detector_pkg::*;

  localparam int N_REQ   = 4;
  localparam int SYM_W   = 5;
  localparam int TIMEOUT = 16;
  localparam int IDW     = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*SYM_W-1:0] req_sym;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_ready;
  logic [SYM_W-1:0]       det_sym;
  logic                   det_valid;
  logic                   det_ready;
  logic                   det_clear;
  logic [IDW-1:0]         grant_id;
  logic                   busy;
  logic [15:0]            pkt_count;
`ifdef ARB_TIMEOUT_EN
  logic                   timeout_flag;
`endif

  detector_stream_arbiter #(.N_REQ(N_REQ), .SYM_W(SYM_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_sym   (req_sym),
    .req_last  (req_last),
    .req_ready (req_ready),
    .det_sym   (det_sym),
    .det_valid (det_valid),
    .det_ready (det_ready),
    .det_clear (det_clear),
    .grant_id  (grant_id),
    .busy      (busy),
`ifdef ARB_TIMEOUT_EN
    .timeout_flag (timeout_flag),
`endif
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SYM_W-1:0] sym;
    logic             last;
    int               gap;
  } item_t;

  typedef struct {
    int cyc;
    int gid;
    int sym;
  } obs_t;

  item_t            srcq [N_REQ][$];
  bit               rdy_q[$];
  logic [N_REQ-1:0] fire = '0;
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  obs_t             obs_q[$];
  int               clr_q[$];

  function automatic item_t mk(input logic [SYM_W-1:0] s, input logic l, input int g);
    item_t it;
    it.sym  = s;
    it.last = l;
    it.gap  = g;
    return it;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Source / detector-ready driver: acts just after each rising edge
  initial begin
    req_valid = '0;
    req_sym   = '0;
    req_last  = '0;
    det_ready = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_sym[i*SYM_W +: SYM_W] = '0;
        if (srcq[i].size() > 0) begin
          item_t it;
          it = srcq[i][0];
          if (it.gap > 0) begin
            it.gap--;
            srcq[i][0] = it;
          end else begin
            req_valid[i] = 1'b1;
            req_last[i]  = it.last;
            req_sym[i*SYM_W +: SYM_W] = it.sym;
          end
        end
      end
      det_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    end
  end

  // Behavioural model and per-cycle comparison on the falling edge
  int  m_owner = -1;
  bit  m_fresh = 0;
  int  m_last  = N_REQ - 1;
  int  m_gid   = 0;
  int  m_pkts  = 0;
  int  m_stall = 0;
  bit  m_pulse = 0;
  bit  m_flag  = 0;

  initial begin
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      if (det_valid && det_ready) obs_q.push_back('{cyc, int'(grant_id), int'(det_sym)});
      if (det_clear) clr_q.push_back(cyc);
      if (reset) begin
        m_owner = -1; m_fresh = 0; m_last = N_REQ - 1; m_gid = 0;
        m_pkts = 0; m_stall = 0; m_pulse = 0; m_flag = 0;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_det_valid", 32'(det_valid), 0);
        chk("rst_det_sym",   32'(det_sym), 0);
        chk("rst_det_clear", 32'(det_clear), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_grant_id",  32'(grant_id), 0);
        chk("rst_pkt_count", 32'(pkt_count), 0);
`ifdef ARB_TIMEOUT_EN
        chk("rst_timeout_flag", 32'(timeout_flag), 0);
`endif
      end else begin
        logic [N_REQ-1:0] e_ready;
        logic             e_valid, e_clear, e_busy, pulse_next;
        logic [SYM_W-1:0] e_sym;
        e_ready = '0; e_valid = 0; e_sym = '0; e_clear = m_pulse; e_busy = 0;
        if (m_owner >= 0) begin
          e_busy = 1;
          if (m_fresh) e_clear = 1;
          else begin
            e_valid = req_valid[m_owner];
            e_sym   = req_sym[m_owner*SYM_W +: SYM_W];
            e_ready[m_owner] = det_ready;
          end
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("det_valid", 32'(det_valid), 32'(e_valid));
        chk("det_sym",   32'(det_sym),   32'(e_sym));
        chk("det_clear", 32'(det_clear), 32'(e_clear));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("grant_id",  32'(grant_id),  32'(m_gid));
        chk("pkt_count", 32'(pkt_count), 32'(m_pkts));
`ifdef ARB_TIMEOUT_EN
        chk("timeout_flag", 32'(timeout_flag), 32'(m_flag));
`endif
        pulse_next = 0;
        if (m_owner < 0) begin
          for (int k = 1; k <= N_REQ; k++) begin
            int c;
            c = (m_last + k) % N_REQ;
            if (m_owner < 0 && req_valid[c]) begin
              m_owner = c; m_gid = c; m_fresh = 1;
            end
          end
        end else if (m_fresh) begin
          m_fresh = 0;
          m_stall = 0;
        end else if (req_valid[m_owner] && det_ready) begin
          m_stall = 0;
          if (req_last[m_owner]) begin
            m_last  = m_owner;
            m_pkts  = (m_pkts + 1) % 65536;
            m_owner = -1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (!req_valid[m_owner] && det_ready) begin
          m_stall++;
          if (m_stall == TIMEOUT) begin
            m_last = m_owner; m_owner = -1; m_flag = 1;
            m_stall = 0; pulse_next = 1;
          end
        end
`endif
        m_pulse = pulse_next;
      end
    end
  end

  task automatic wait_idle(input int max, output int at);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
      done = !busy && srcq[0].size() == 0 && srcq[1].size() == 0 &&
             srcq[2].size() == 0 && srcq[3].size() == 0;
    end
    at = cyc;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle cyc=%0d got=busy expected=idle within %0d cycles", cyc, max);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int i = 0; i < N_REQ; i++) srcq[i].delete();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Directed scenarios
  initial begin
    int t0, n0, nc0, at, pk;
    int exp1[4];
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_pkt_count", 32'(pkt_count), 0);
    chk("reset_grant_id",  32'(grant_id), 0);
    release_reset();
    @(negedge clk);

    // Source 2 sends C,A,S,A(last)
    exp1 = '{3, 1, 20, 1};
    srcq[2].push_back(mk(SYM_C, 0, 0));
    srcq[2].push_back(mk(SYM_A, 0, 0));
    srcq[2].push_back(mk(SYM_S, 0, 0));
    srcq[2].push_back(mk(SYM_A, 1, 0));
    n0 = obs_q.size(); nc0 = clr_q.size();
    @(negedge clk);
    t0 = cyc;
    wait_idle(40, at);
    chk("t1_idle_cycle", 32'(at), 32'(t0 + 6));
    chk("t1_xfer_count", 32'(obs_q.size() - n0), 4);
    chk("t1_clear_cycle", 32'(clr_q[nc0]), 32'(t0 + 1));
    chk("t1_clear_count", 32'(clr_q.size() - nc0), 1);
    for (int k = 0; k < 4; k++) begin
      chk("t1_sym",  32'(obs_q[n0+k].sym), 32'(exp1[k]));
      chk("t1_gid",  32'(obs_q[n0+k].gid), 2);
      chk("t1_xcyc", 32'(obs_q[n0+k].cyc), 32'(t0 + 2 + k));
    end
    chk("t1_pkt_count", 32'(pkt_count), 1);

    // Sources 0 and 1 valid from reset, two 2-symbol words each
    do_reset();
    srcq[0].push_back(mk(SYM_A, 0, 0)); srcq[0].push_back(mk(SYM_C, 1, 0));
    srcq[0].push_back(mk(SYM_A, 0, 0)); srcq[0].push_back(mk(SYM_C, 1, 0));
    srcq[1].push_back(mk(SYM_S, 0, 0)); srcq[1].push_back(mk(SYM_A, 1, 0));
    srcq[1].push_back(mk(SYM_S, 0, 0)); srcq[1].push_back(mk(SYM_A, 1, 0));
    repeat (2) @(negedge clk);
    n0 = obs_q.size(); nc0 = clr_q.size();
    release_reset();
    wait_idle(80, at);
    chk("t2_xfer_count", 32'(obs_q.size() - n0), 8);
    chk("t2_clear_count", 32'(clr_q.size() - nc0), 4);
    chk("t2_pkt_count", 32'(pkt_count), 4);
    if (obs_q.size() - n0 == 8) begin
      for (int w = 0; w < 4; w++) begin
        chk("t2_grant_order", 32'(obs_q[n0+2*w+1].gid), 32'(w % 2));
        chk("t2_in_word", 32'(obs_q[n0+2*w+1].cyc - obs_q[n0+2*w].cyc), 1);
        if (w < 3) chk("t2_word_gap", 32'(obs_q[n0+2*w+2].cyc - obs_q[n0+2*w+1].cyc), 3);
      end
    end

    // det_ready pattern 1,0,0,1 across a 3-symbol word from source 1
    @(negedge clk);
    srcq[1].push_back(mk(SYM_C, 0, 0));
    srcq[1].push_back(mk(SYM_S, 0, 0));
    srcq[1].push_back(mk(SYM_A, 1, 0));
    rdy_q = '{1, 1, 1, 0, 0, 1, 1};
    n0 = obs_q.size();
    @(negedge clk);
    t0 = cyc;
    wait_idle(40, at);
    chk("t3_xfer_count", 32'(obs_q.size() - n0), 3);
    if (obs_q.size() - n0 == 3) begin
      chk("t3_sym0", 32'(obs_q[n0].sym), 3);
      chk("t3_sym1", 32'(obs_q[n0+1].sym), 20);
      chk("t3_sym2", 32'(obs_q[n0+2].sym), 1);
      chk("t3_cyc0", 32'(obs_q[n0].cyc), 32'(t0 + 2));
      chk("t3_cyc1", 32'(obs_q[n0+1].cyc), 32'(t0 + 5));
      chk("t3_cyc2", 32'(obs_q[n0+2].cyc), 32'(t0 + 6));
    end
    chk("t3_pkt_count", 32'(pkt_count), 5);

    // Single-symbol word from source 3
    @(negedge clk);
    pk = int'(pkt_count);
    srcq[3].push_back(mk(SYM_S, 1, 0));
    n0 = obs_q.size(); nc0 = clr_q.size();
    @(negedge clk);
    t0 = cyc;
    wait_idle(20, at);
    chk("t4_idle_cycle", 32'(at), 32'(t0 + 3));
    chk("t4_clear_cycle", 32'(clr_q[nc0]), 32'(t0 + 1));
    chk("t4_xfer_count", 32'(obs_q.size() - n0), 1);
    chk("t4_xfer_cyc", 32'(obs_q[n0].cyc), 32'(t0 + 2));
    chk("t4_gid", 32'(obs_q[n0].gid), 3);
    chk("t4_pkt_inc", 32'(pkt_count), 32'(pk + 1));

    // Reset in STREAM after two symbols of a word from source 2
    @(negedge clk);
    srcq[2].push_back(mk(SYM_C, 0, 0));
    srcq[2].push_back(mk(SYM_A, 0, 0));
    srcq[2].push_back(mk(SYM_S, 0, 0));
    srcq[2].push_back(mk(SYM_A, 1, 0));
    n0 = obs_q.size(); nc0 = clr_q.size();
    @(negedge clk);
    repeat (3) @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("t5_xfers_before_reset", 32'(obs_q.size() - n0), 2);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_det_valid", 32'(det_valid), 0);
    chk("t5_pkt_count", 32'(pkt_count), 0);
    release_reset();
    @(negedge clk);
    srcq[2].push_back(mk(SYM_A, 1, 0));
    srcq[0].push_back(mk(SYM_C, 1, 0));
    n0 = obs_q.size();
    wait_idle(40, at);
    chk("t5_xfer_count", 32'(obs_q.size() - n0), 2);
    if (obs_q.size() - n0 == 2) begin
      chk("t5_first_gid", 32'(obs_q[n0].gid), 0);
      chk("t5_second_gid", 32'(obs_q[n0+1].gid), 2);
    end
    chk("t5_pkt_after", 32'(pkt_count), 2);

`ifdef ARB_TIMEOUT_EN
    // Source 1 stalls for 20 cycles mid-word while source 3 waits
    @(negedge clk);
    pk = int'(pkt_count);
    chk("t6_flag_before", 32'(timeout_flag), 0);
    srcq[1].push_back(mk(SYM_C, 0, 0));
    srcq[1].push_back(mk(SYM_A, 1, 20));
    srcq[3].push_back(mk(SYM_S, 1, 0));
    n0 = obs_q.size(); nc0 = clr_q.size();
    @(negedge clk);
    t0 = cyc;
    wait_idle(80, at);
    chk("t6_flag", 32'(timeout_flag), 1);
    chk("t6_pkt_count", 32'(pkt_count), 32'(pk + 2));
    chk("t6_clear_count", 32'(clr_q.size() - nc0), 4);
    if (clr_q.size() - nc0 == 4) begin
      chk("t6_abort_clear", 32'(clr_q[nc0+1]), 32'(t0 + 19));
      chk("t6_next_clear",  32'(clr_q[nc0+2]), 32'(t0 + 20));
    end
    chk("t6_xfer_count", 32'(obs_q.size() - n0), 3);
    if (obs_q.size() - n0 == 3) begin
      chk("t6_next_gid", 32'(obs_q[n0+1].gid), 3);
      chk("t6_next_cyc", 32'(obs_q[n0+1].cyc), 32'(t0 + 21));
      chk("t6_resume_gid", 32'(obs_q[n0+2].gid), 1);
    end
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
